prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 32768: largest accepted image size in 16-bit words, at most 2^15.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level sampled each cycle; begins a load session when the block is idle.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-008 rom_we  output  1  instruction-memory write strobe.
REQ-009 rom_addr  output  15  instruction-memory write address.
REQ-010 rom_data  output  16  instruction-memory write data.
REQ-011 cpu_reset  output  1  holds the CPU in reset while an image is loaded.
REQ-012 busy  output  1  a load session is in progress.
REQ-013 done  output  1  last session completed with a good checksum.
REQ-014 error  output  1  last session was aborted.

Function
REQ-015 Stream format: LEN_HI, LEN_LO (word count N, big-endian); then N words, each sent high byte then low byte; then one checksum byte.
REQ-016 Checksum rule: the 8-bit modulo-256 sum of every byte from LEN_HI through the checksum byte SHALL equal 0x00.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR with start=1 -> LEN_HI on the next edge; done and error clear; busy and cpu_reset set.
REQ-019 in_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 otherwise.
REQ-020 A byte transfer advances LEN_HI->LEN_LO, DATA_HI->DATA_LO and DATA_LO->DATA_HI; without a transfer the state holds indefinitely, with no timeout.
REQ-021 LEN_LO transfer:
- N=0 or N>MAX_WORDS -> ERROR, with the remaining bytes unconsumed;
- otherwise -> DATA_HI with the word index cleared to 0.
REQ-022 DATA_LO transfer: on the following edge rom_we=1 for exactly one cycle, rom_addr=word index, rom_data={high byte, low byte}; the index then increments.
REQ-023 After the Nth word's DATA_LO transfer the block goes to CHECK instead of DATA_HI.
REQ-024 CHECK transfer:
- total sum 0 -> DONE: done=1, busy=0, cpu_reset=0;
- total sum nonzero -> ERROR: error=1, busy=0, cpu_reset stays 1.
REQ-025 done and error are levels; they hold until the next session starts or reset.
REQ-026 rom_addr and rom_data SHALL hold their last values when rom_we=0.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 The word index never wraps: N is bounded by MAX_WORDS, so the maximum index is MAX_WORDS-1.
REQ-029 Throughput: one byte per cycle sustained; back-to-back words give a rom_we pulse every second cycle.
REQ-030 All outputs SHALL be registered; none is combinationally derived from in_valid or start.

Reset
REQ-031 On reset=1 at an edge:
- state -> IDLE;
- in_ready=0, rom_we=0, rom_addr=0, rom_data=0, cpu_reset=0, busy=0, done=0, error=0;
- checksum and index cleared.
REQ-032 Reset mid-session: aborts immediately; no rom_we pulse occurs after the reset edge, including a write pending from a DATA_LO transfer on that same edge.
REQ-033 Reset has priority over start and byte transfers in the same cycle.

Structure
REQ-034 A shared package loader_pkg SHALL hold the state enum, ADDR_W=15, WORD_W=16 and BYTE_W=8.
REQ-035 The running checksum (clear, accumulate-on-transfer, is-zero flag) SHALL be a sub-module named prog_loader_cksum.
REQ-036 The top level SHALL contain only the FSM, byte assembler, word index and output registers.

Verification
REQ-037 Stream 00 02 12 34 AB CD 40 after start -> rom_we pulses (0,0x1234) then (1,0xABCD); done=1, cpu_reset=0, error=0.
REQ-038 The same stream with checksum byte 41 -> both writes occur, then error=1 and cpu_reset=1; done=0.
REQ-039 Length bytes 00 00 -> error=1 after LEN_LO; no rom_we; in_ready=0.
REQ-040 in_valid toggled randomly 50% over the REQ-037 stream -> identical writes and final status; no byte lost or duplicated.
REQ-041 reset pulsed on the edge that transfers the first word's low byte -> no rom_we; all outputs at reset values; a subsequent REQ-037 session succeeds.
REQ-042 start held high throughout a session -> no restart mid-stream; a new session begins on the edge immediately after DONE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader: FSM state encoding,
// bus widths and a helper that says which states accept stream bytes.
package loader_pkg;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // True for every state in which the loader is consuming stream bytes.
    function automatic logic is_rx(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Session control, byte-stream handshake and instruction-memory write bus.
// master = stream source / supervisor, slave = the loader itself.
interface prog_loader_if;
    import loader_pkg::*;

    logic              start;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, rom_we, rom_addr, rom_data, cpu_reset, busy, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, rom_we, rom_addr, rom_data, cpu_reset, busy, done, error
    );

endinterface

// File: rtl/prog_loader_cksum.sv
// Running modulo-256 byte checksum. sum_zero reports whether the total,
// including the byte currently presented on add_data, comes to zero, so the
// FSM can judge the checksum byte on the very edge that transfers it.
module prog_loader_cksum
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] add_data,
    output logic              sum_zero
);

    logic [BYTE_W-1:0] sum_reg;
    logic [BYTE_W-1:0] sum_with;

    assign sum_with = sum_reg + add_data;
    assign sum_zero = (sum_with == '0);

    // Accumulate every transferred byte; cleared at reset and session start.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_reg <= '0;
        end else if (add_en) begin
            sum_reg <= sum_with;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot image loader: receives a length-prefixed, checksummed byte stream,
// writes 16-bit words into instruction memory and holds the CPU in reset
// until a complete image with a good checksum has been received.
module prog_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = 32768
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t              state_reg, state_next;
    logic                start_accept;
    logic                xfer;
    logic                sum_zero;
    logic                len_bad;
    logic                last_word;
    logic [15:0]         n_next;

    logic [BYTE_W-1:0]   len_hi_reg;
    logic [15:0]         n_reg;
    logic [BYTE_W-1:0]   hi_reg;
    logic [ADDR_W-1:0]   idx_reg;

    logic                in_ready_reg;
    logic                rom_we_reg;
    logic [ADDR_W-1:0]   rom_addr_reg;
    logic [WORD_W-1:0]   rom_data_reg;
    logic                cpu_reset_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                error_reg;

    // in_ready is a register, so a transfer only depends on it and in_valid.
    assign xfer      = bus.in_valid && in_ready_reg;
    assign n_next    = {len_hi_reg, bus.in_data};
    assign len_bad   = (n_next == 16'd0) || ({1'b0, n_next} > MAX_W);
    assign last_word = ({1'b0, idx_reg} == (n_reg - 16'd1));

    prog_loader_cksum u_cksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_accept),
        .add_en   (xfer),
        .add_data (bus.in_data),
        .sum_zero (sum_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: sessions start only from a resting state, and each
    // receive state advances only on a byte transfer (no timeout).
    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    state_next   = ST_LEN_HI;
                    start_accept = 1'b1;
                end
            end
            ST_LEN_HI:  if (xfer) state_next = ST_LEN_LO;
            ST_LEN_LO:  if (xfer) state_next = len_bad ? ST_ERROR : ST_DATA_HI;
            ST_DATA_HI: if (xfer) state_next = ST_DATA_LO;
            ST_DATA_LO: if (xfer) state_next = last_word ? ST_CHECK : ST_DATA_HI;
            ST_CHECK:   if (xfer) state_next = sum_zero ? ST_DONE : ST_ERROR;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Byte assembly, word index and registered outputs (derived from the
    // next state so status flags line up with the state they describe).
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi_reg    <= '0;
            n_reg         <= '0;
            hi_reg        <= '0;
            idx_reg       <= '0;
            in_ready_reg  <= 1'b0;
            rom_we_reg    <= 1'b0;
            rom_addr_reg  <= '0;
            rom_data_reg  <= '0;
            cpu_reset_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            in_ready_reg <= is_rx(state_next);
            busy_reg     <= is_rx(state_next);
            done_reg     <= (state_next == ST_DONE);
            error_reg    <= (state_next == ST_ERROR);
            rom_we_reg   <= 1'b0;

            // The CPU is released only by a good image; an aborted load keeps it held.
            if (start_accept) begin
                cpu_reset_reg <= 1'b1;
            end else if (state_next == ST_DONE) begin
                cpu_reset_reg <= 1'b0;
            end

            if (xfer) begin
                case (state_reg)
                    ST_LEN_HI:  len_hi_reg <= bus.in_data;
                    ST_LEN_LO: begin
                        n_reg   <= n_next;
                        idx_reg <= '0;
                    end
                    ST_DATA_HI: hi_reg <= bus.in_data;
                    ST_DATA_LO: begin
                        rom_we_reg   <= 1'b1;
                        rom_addr_reg <= idx_reg;
                        rom_data_reg <= {hi_reg, bus.in_data};
                        // Hold at the last index rather than wrapping past MAX_WORDS-1.
                        if (!last_word) begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.rom_we    = rom_we_reg;
    assign bus.rom_addr  = rom_addr_reg;
    assign bus.rom_data  = rom_data_reg;
    assign bus.cpu_reset = cpu_reset_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.error     = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed streams plus randomized
// images and handshake throttling, compared against a stream-level model.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int MAXW  = 16;
    localparam int GUARD = 4000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    prog_loader_if bus ();

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [30:0] got_q[$];
    logic [30:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;
    int          n_pass   = 0;
    int          n_checks = 0;

    // Record every memory write as {addr, data}.
    always @(negedge clk) begin
        if (bus.rom_we === 1'b1) got_q.push_back({bus.rom_addr, bus.rom_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Reference: parse the stream by its documented format.
    task automatic model(input logic [7:0] bs[$]);
        int n;
        logic [7:0] s;
        exp_q.delete();
        n = int'({bs[0], bs[1]});
        if (n == 0 || n > MAXW) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) exp_q.push_back({15'(k), bs[2+2*k], bs[3+2*k]});
        s = 8'h00;
        for (int k = 0; k < 2*n + 3; k++) s = s + bs[k];
        exp_done = (s == 8'h00);
        exp_err  = !exp_done;
    endtask

    task automatic build(input int n, input bit good, output logic [7:0] bs[$]);
        logic [7:0] s;
        logic [15:0] nn;
        bs.delete();
        nn = 16'(n);
        bs.push_back(nn[15:8]);
        bs.push_back(nn[7:0]);
        for (int k = 0; k < 2*n; k++) bs.push_back(8'($urandom_range(255)));
        s = 8'h00;
        foreach (bs[k]) s = s + bs[k];
        s = 8'h00 - s;
        if (!good) s = s + 8'($urandom_range(1, 255));
        bs.push_back(s);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_rom_we",    bus.rom_we,    0);
        check("rst_rom_addr",  bus.rom_addr,  0);
        check("rst_rom_data",  bus.rom_data,  0);
        check("rst_cpu_reset", bus.cpu_reset, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_done",      bus.done,      0);
        check("rst_error",     bus.error,     0);
    endtask

    task automatic check_writes();
        check("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("write_addr", 32'(got_q[i][30:16]), 32'(exp_q[i][30:16]));
            check("write_data", 32'(got_q[i][15:0]),  32'(exp_q[i][15:0]));
        end
    endtask

    // Drive one session; prob is the percent chance of in_valid per cycle.
    task automatic run_session(input string name, input logic [7:0] bs[$], input int prob, input bit hold);
        int i, guard, stalls;
        bit xfer;
        model(bs);
        got_q.delete();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = hold;
        i = 0; guard = 0; stalls = 0;
        while (i < bs.size() && bus.busy && guard < GUARD) begin
            bus.in_valid = (prob >= 100) ? 1'b1 : ($urandom_range(99) < prob);
            bus.in_data  = bs[i];
            xfer = bus.in_valid && bus.in_ready;
            if (!xfer) stalls++;
            @(negedge clk);
            if (xfer) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        check("no_timeout", 32'(guard < GUARD), 1);
        if (prob >= 100) check("stalls", stalls, 0);
        if (hold) begin
            check_writes();
            check("hold_done", bus.done, 32'(exp_done));
            @(negedge clk);
            check("restart_busy", bus.busy, 1);
            check("restart_done", bus.done, 0);
            bus.start = 1'b0;
            pulse_reset();
        end else begin
            @(negedge clk);
            check_writes();
            check("done",      bus.done,      32'(exp_done));
            check("error",     bus.error,     32'(exp_err));
            check("cpu_reset", bus.cpu_reset, 32'(exp_err));
            check("busy_end",  bus.busy,      0);
            check("ready_end", bus.in_ready,  0);
            check("rom_we_end", bus.rom_we,   0);
        end
        $display("session %s: bytes=%0d consumed=%0d writes=%0d done=%0b error=%0b",
                 name, bs.size(), i, got_q.size(), bus.done, bus.error);
    endtask

    logic [7:0] s_good[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    logic [7:0] s_bad[$]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    logic [7:0] s_zero[$] = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h00};
    logic [7:0] s_big[$]  = '{8'h00, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] bs[$];

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs();
        $display("reset: outputs checked");

        run_session("good",      s_good, 100, 1'b0);
        run_session("bad_cksum", s_bad,  100, 1'b0);
        run_session("len_zero",  s_zero, 100, 1'b0);
        run_session("len_over",  s_big,  100, 1'b0);
        run_session("throttled", s_good, 50,  1'b0);

        // Reset on the edge that would transfer the first word's low byte.
        got_q.delete();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = s_good[k];
            @(negedge clk);
        end
        bus.in_data = s_good[3]; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("midreset_writes", got_q.size(), 0);
        check_reset_outputs();
        $display("session midreset: writes=%0d", got_q.size());
        run_session("after_reset", s_good, 100, 1'b0);

        run_session("start_held", s_good, 100, 1'b1);

        build(MAXW, 1'b1, bs);
        run_session("max_words", bs, 100, 1'b0);

        for (int r = 0; r < 12; r++) begin
            build($urandom_range(1, MAXW), 1'($urandom_range(1)), bs);
            run_session("random", bs, $urandom_range(30, 100), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
